// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its UART front-end: opcode values,
// sequencer state encoding and the byte returned for a rejected opcode.
package alu_pkg;

   localparam logic [5:0] ADD = 6'h20;
   localparam logic [5:0] SUB = 6'h22;
   localparam logic [5:0] AND = 6'h24;
   localparam logic [5:0] OR  = 6'h25;
   localparam logic [5:0] XOR = 6'h26;
   localparam logic [5:0] SRA = 6'h03;
   localparam logic [5:0] SRL = 6'h02;
   localparam logic [5:0] NOR = 6'h27;

   localparam logic [7:0] ERR_BYTE = 8'hEE;

   typedef enum logic [3:0] {
      WAIT_A,
      WAIT_B,
      WAIT_OP,
      EXEC,
      CAPTURE,
      SEND_LO,
      WAIT_LO,
      SEND_HI,
      WAIT_HI
   } seqState_t;

endpackage

// File: rtl/alu_uart_sequencer_op_validator.sv
// Combinational check that a received byte is one of the supported ALU opcodes.
module op_validator
   import alu_pkg::*;
(
   input  logic [7:0] opByte,
   output logic       opValid
);

   // The two bits above the 6-bit funct field must be clear for a legal opcode.
   always_comb begin
      opValid = 1'b0;
      if (opByte[7:6] == 2'b00) begin
         case (opByte[5:0])
            ADD, SUB, AND, OR, XOR, SRA, SRL, NOR: opValid = 1'b1;
            default:                               opValid = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Byte-stream front-end for the ALU: gathers A, B and opcode from the UART
// receiver, strobes them into the ALU and returns the 9-bit result as two bytes.
module alu_uart_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 6
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   input  logic [DATA_WIDTH:0]   i_alu_result,
   input  logic                  i_alu_carry,
   input  logic                  i_tx_done,
   output logic [DATA_WIDTH-1:0] o_alu_a,
   output logic [DATA_WIDTH-1:0] o_alu_b,
   output logic [OP_WIDTH-1:0]   o_alu_op,
   output logic                  o_load_a,
   output logic                  o_load_b,
   output logic                  o_load_op,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_start,
   output logic                  o_busy,
   output logic                  o_op_error
);

   seqState_t state, nextState;

   logic       opValid;
   logic [7:0] hiByte;
   logic       txStart;

   op_validator opCheck (
      .opByte (i_rx_data),
      .opValid(opValid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= WAIT_A;
      else       state <= nextState;
   end

   // Received bytes are only honoured in the three collection states; a bad
   // opcode skips the low byte and goes straight to sending the error byte.
   always_comb begin
      nextState = state;
      txStart   = 1'b0;
      case (state)
         WAIT_A:  if (i_rx_done) nextState = WAIT_B;
         WAIT_B:  if (i_rx_done) nextState = WAIT_OP;
         WAIT_OP: if (i_rx_done) nextState = opValid ? EXEC : SEND_HI;
         EXEC:    nextState = CAPTURE;
         CAPTURE: nextState = SEND_LO;
         SEND_LO: begin
            txStart   = 1'b1;
            nextState = WAIT_LO;
         end
         WAIT_LO: if (i_tx_done) nextState = SEND_HI;
         SEND_HI: begin
            txStart   = 1'b1;
            nextState = WAIT_HI;
         end
         WAIT_HI: if (i_tx_done) nextState = WAIT_A;
         default: nextState = WAIT_A;
      endcase
   end

   // Operand/opcode registers and their strobes update together, so each
   // strobe is seen alongside the value it announces.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_alu_a    <= '0;
         o_alu_b    <= '0;
         o_alu_op   <= '0;
         o_load_a   <= 1'b0;
         o_load_b   <= 1'b0;
         o_load_op  <= 1'b0;
         o_tx_data  <= 8'h00;
         o_op_error <= 1'b0;
         hiByte     <= 8'h00;
      end else begin
         o_load_a  <= 1'b0;
         o_load_b  <= 1'b0;
         o_load_op <= 1'b0;
         case (state)
            WAIT_A: if (i_rx_done) begin
               o_alu_a    <= DATA_WIDTH'(i_rx_data);
               o_load_a   <= 1'b1;
               o_op_error <= 1'b0;
            end
            WAIT_B: if (i_rx_done) begin
               o_alu_b  <= DATA_WIDTH'(i_rx_data);
               o_load_b <= 1'b1;
            end
            WAIT_OP: if (i_rx_done) begin
               if (opValid) begin
                  o_alu_op  <= OP_WIDTH'(i_rx_data);
                  o_load_op <= 1'b1;
               end else begin
                  o_op_error <= 1'b1;
                  o_tx_data  <= ERR_BYTE;
               end
            end
            CAPTURE: begin
               o_tx_data <= i_alu_result[7:0];
               hiByte    <= {6'b000000, i_alu_carry, i_alu_result[DATA_WIDTH]};
            end
            WAIT_LO: if (i_tx_done) o_tx_data <= hiByte;
            default: ;
         endcase
      end
   end

   assign o_tx_start = txStart;
   assign o_busy     = (state != WAIT_A);

endmodule
